// File: rtl/ls_mem_arbiter_if.sv
// Processor-side requester ports and the processor/memory bus of the load/store memory arbiter.
interface ls_mem_arbiter_if #(
  parameter int LSQ_IDX_LEN = 3,
  parameter int TAG_W       = 4
);
  logic                   st_req_valid;
  logic [31:0]            st_req_addr;
  logic [63:0]            st_req_data;
  logic [1:0]             st_req_size;
  logic                   st_ack;

  logic                   ld_req_valid;
  logic [31:0]            ld_req_addr;
  logic [1:0]             ld_req_size;
  logic [LSQ_IDX_LEN-1:0] ld_req_lq_pos;
  logic                   ld_ack;
  logic                   ld_ret_valid;
  logic [63:0]            ld_ret_data;
  logic [LSQ_IDX_LEN-1:0] ld_ret_lq_pos;

  logic                   ic_req_valid;
  logic [31:0]            ic_req_addr;
  logic [TAG_W-1:0]       ic_ack_tag;

  logic [1:0]             proc2mem_command;
  logic [31:0]            proc2mem_addr;
  logic [63:0]            proc2mem_data;
  logic [1:0]             proc2mem_size;
  logic [TAG_W-1:0]       mem2proc_response;
  logic [63:0]            mem2proc_data;
  logic [TAG_W-1:0]       mem2proc_tag;

  modport master (
    input  st_req_valid, st_req_addr, st_req_data, st_req_size,
    input  ld_req_valid, ld_req_addr, ld_req_size, ld_req_lq_pos,
    input  ic_req_valid, ic_req_addr,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output st_ack, ld_ack, ld_ret_valid, ld_ret_data, ld_ret_lq_pos, ic_ack_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
  );

  modport slave (
    output st_req_valid, st_req_addr, st_req_data, st_req_size,
    output ld_req_valid, ld_req_addr, ld_req_size, ld_req_lq_pos,
    output ic_req_valid, ic_req_addr,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  st_ack, ld_ack, ld_ret_valid, ld_ret_data, ld_ret_lq_pos, ic_ack_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
  );
endinterface

// File: rtl/ls_mem_arbiter.sv
// Shares the memory port among store drain, load issue and icache fetch, and routes
// returning load data to its load-queue slot by memory tag.
module ls_mem_arbiter #(
  parameter int LSQ_IDX_LEN  = 3,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  ls_mem_arbiter_if.master bus,
  output logic [TAG_W:0]   outstanding_loads
);
  localparam int NUM_TAGS = 2 ** TAG_W;
  localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} bus_cmd_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_ST, GNT_LD, GNT_IC} grant_e;

  grant_e                 grant;
  bus_cmd_e               cmd;
  logic                   accepted;
  logic                   ic_top;
  logic                   ret_hit;
  logic                   ld_alloc;
  logic [CNT_W-1:0]       ic_starve_cnt;
  logic [NUM_TAGS-1:0]    tag_valid;
  logic [NUM_TAGS-1:0]    valid_next;
  logic [LSQ_IDX_LEN-1:0] tag_pos [NUM_TAGS];
  logic [TAG_W:0]         live_cnt;

  always_comb begin
    ic_top   = ic_starve_cnt >= STARVE_MAX;
    accepted = bus.mem2proc_response != '0;
    grant    = GNT_NONE;
    if (reset)                             grant = GNT_NONE;
    else if (bus.ic_req_valid && ic_top)   grant = GNT_IC;
    else if (bus.st_req_valid)             grant = GNT_ST;
    else if (bus.ld_req_valid)             grant = GNT_LD;
    else if (bus.ic_req_valid)             grant = GNT_IC;

    cmd                = BUS_NONE;
    bus.proc2mem_addr  = '0;
    bus.proc2mem_data  = '0;
    bus.proc2mem_size  = '0;
    case (grant)
      GNT_ST: begin
        cmd               = BUS_STORE;
        bus.proc2mem_addr = bus.st_req_addr;
        bus.proc2mem_data = bus.st_req_data;
        bus.proc2mem_size = bus.st_req_size;
      end
      GNT_LD: begin
        cmd               = BUS_LOAD;
        bus.proc2mem_addr = bus.ld_req_addr;
        bus.proc2mem_size = bus.ld_req_size;
      end
      GNT_IC: begin
        cmd               = BUS_LOAD;
        bus.proc2mem_addr = bus.ic_req_addr;
        bus.proc2mem_size = SIZE_DOUBLE;
      end
      default: ;
    endcase
    bus.proc2mem_command = cmd;

    bus.st_ack     = (grant == GNT_ST) && accepted;
    bus.ld_ack     = (grant == GNT_LD) && accepted;
    bus.ic_ack_tag = (grant == GNT_IC && accepted) ? bus.mem2proc_response : '0;
  end

  // Icache tags never get a table entry, so they can never produce a load return.
  always_comb begin
    ret_hit           = !reset && (bus.mem2proc_tag != '0) && tag_valid[bus.mem2proc_tag];
    bus.ld_ret_valid  = ret_hit && !squash;
    bus.ld_ret_data   = bus.mem2proc_data;
    bus.ld_ret_lq_pos = tag_pos[bus.mem2proc_tag];
    ld_alloc          = bus.ld_ack && !squash;

    // Return clears before allocation so a reused tag ends up live with its new owner.
    valid_next = tag_valid;
    if (ret_hit)  valid_next[bus.mem2proc_tag] = 1'b0;
    if (squash)   valid_next = '0;
    if (ld_alloc) valid_next[bus.mem2proc_response] = 1'b1;

    live_cnt = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++)
      live_cnt = live_cnt + (TAG_W + 1)'(valid_next[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid         <= '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) tag_pos[i] <= '0;
      ic_starve_cnt     <= '0;
      outstanding_loads <= '0;
    end else begin
      tag_valid         <= valid_next;
      outstanding_loads <= live_cnt;
      if (ld_alloc) tag_pos[bus.mem2proc_response] <= bus.ld_req_lq_pos;
      if (!bus.ic_req_valid || (grant == GNT_IC && accepted))
        ic_starve_cnt <= '0;
      else if (ic_starve_cnt < STARVE_MAX)
        ic_starve_cnt <= ic_starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ls_mem_arbiter.sv
// Randomized and directed bench for ls_mem_arbiter against a tag-table reference model.
module tb_ls_mem_arbiter;
  localparam int LSQ = 3;
  localparam int TW  = 4;
  localparam int SL  = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          squash;
  logic [TW:0]   outstanding_loads;

  ls_mem_arbiter_if #(.LSQ_IDX_LEN(LSQ), .TAG_W(TW)) bus ();

  ls_mem_arbiter #(.LSQ_IDX_LEN(LSQ), .TAG_W(TW), .STARVE_LIMIT(SL)) dut (
    .clock(clock),
    .reset(reset),
    .squash(squash),
    .bus(bus.master),
    .outstanding_loads(outstanding_loads)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  bit             m_valid [16];
  logic [LSQ-1:0] m_pos   [16];
  int             m_starve;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int live_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic bit req_v(input int who);
    case (who)
      1: return bus.st_req_valid;
      2: return bus.ld_req_valid;
      3: return bus.ic_req_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input bit sv, input bit lv, input bit iv, input int lq,
                       input int resp, input int tag, input logic [63:0] md);
    bus.st_req_valid      = sv;
    bus.st_req_addr       = $urandom;
    bus.st_req_data       = {$urandom, $urandom};
    bus.st_req_size       = 2'($urandom_range(0, 3));
    bus.ld_req_valid      = lv;
    bus.ld_req_addr       = $urandom;
    bus.ld_req_size       = 2'($urandom_range(0, 3));
    bus.ld_req_lq_pos     = LSQ'(lq);
    bus.ic_req_valid      = iv;
    bus.ic_req_addr       = $urandom & 32'hFFFF_FFF8;
    bus.mem2proc_response = TW'(resp);
    bus.mem2proc_tag      = TW'(tag);
    bus.mem2proc_data     = md;
  endtask

  // Called just after a falling edge with inputs applied; checks, clocks, updates the model.
  task automatic cycle();
    int order [3];
    int w;
    int rt;
    bit acc, eret, clr_ic;
    logic [1:0]  ecmd, esize;
    logic [31:0] eaddr;
    #1;
    w = 0;
    if (!reset) begin
      if (bus.ic_req_valid && m_starve >= SL) order = '{3, 1, 2};
      else                                    order = '{1, 2, 3};
      for (int k = 0; k < 3; k++) if (w == 0 && req_v(order[k])) w = order[k];
    end
    acc   = bus.mem2proc_response != 0;
    ecmd  = (w == 0) ? 2'd0 : (w == 1) ? 2'd2 : 2'd1;
    eaddr = (w == 1) ? bus.st_req_addr : (w == 2) ? bus.ld_req_addr :
            (w == 3) ? bus.ic_req_addr : 32'd0;
    esize = (w == 1) ? bus.st_req_size : (w == 2) ? bus.ld_req_size :
            (w == 3) ? 2'd3 : 2'd0;
    check("cmd", bus.proc2mem_command, ecmd);
    check("addr", bus.proc2mem_addr, eaddr);
    check("size", bus.proc2mem_size, esize);
    if (w == 1)      check("st_data", bus.proc2mem_data, bus.st_req_data);
    else if (w == 0) check("idle_data", bus.proc2mem_data, 64'd0);
    check("st_ack", bus.st_ack, (w == 1) && acc);
    check("ld_ack", bus.ld_ack, (w == 2) && acc);
    check("ic_ack_tag", bus.ic_ack_tag, (w == 3 && acc) ? bus.mem2proc_response : 4'd0);
    rt   = int'(bus.mem2proc_tag);
    eret = !reset && !squash && rt != 0 && m_valid[rt];
    check("ret_valid", bus.ld_ret_valid, eret);
    if (eret) begin
      check("ret_pos", bus.ld_ret_lq_pos, m_pos[rt]);
      check("ret_data", bus.ld_ret_data, bus.mem2proc_data);
    end
    clr_ic = !bus.ic_req_valid || (w == 3 && acc);
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_starve = 0;
    end else begin
      if (rt != 0) m_valid[rt] = 1'b0;
      if (squash) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      if (w == 2 && acc && !squash) begin
        m_valid[bus.mem2proc_response] = 1'b1;
        m_pos[bus.mem2proc_response]   = bus.ld_req_lq_pos;
      end
      m_starve = clr_ic ? 0 : m_starve + 1;
    end
    #1;
    check("outstanding", outstanding_loads, (TW+1)'(live_count()));
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_pos[i] = '0; end
    m_starve = 0;
    reset  = 1'b1;
    squash = 1'b0;
    drive(1, 1, 1, 0, 3, 0, 64'd0);
    @(negedge clock);
    #1;
    check("rst_cmd", bus.proc2mem_command, 2'd0);
    check("rst_st_ack", bus.st_ack, 1'b0);
    check("rst_ic_tag", bus.ic_ack_tag, 4'd0);
    cycle();
    check("rst_outstanding", outstanding_loads, 5'd0);
    reset = 1'b0;

    // store beats load, then load gets tag 4
    drive(1, 1, 0, 6, 3, 0, 64'd0); #1;
    check("pri_cmd_store", bus.proc2mem_command, 2'd2);
    check("pri_st_ack", bus.st_ack, 1'b1);
    check("pri_ld_ack", bus.ld_ack, 1'b0);
    cycle();
    drive(0, 1, 0, 6, 4, 0, 64'd0); #1;
    check("ld_cmd", bus.proc2mem_command, 2'd1);
    check("ld_ack4", bus.ld_ack, 1'b1);
    cycle();
    check("out_after_ld", outstanding_loads, 5'd1);

    // lq_pos 5 on tag 7, then both returns
    drive(0, 1, 0, 5, 7, 0, 64'd0); cycle();
    drive(0, 0, 0, 0, 0, 7, 64'hDEADBEEF_00000001); #1;
    check("ret7_valid", bus.ld_ret_valid, 1'b1);
    check("ret7_pos", bus.ld_ret_lq_pos, 3'd5);
    check("ret7_data", bus.ld_ret_data, 64'hDEADBEEF_00000001);
    cycle();
    drive(0, 0, 0, 0, 0, 4, 64'h1234); #1;
    check("ret4_pos", bus.ld_ret_lq_pos, 3'd6);
    cycle();
    check("out_drained", outstanding_loads, 5'd0);

    // icache starvation against a continuous store
    for (int i = 0; i < SL; i++) begin
      drive(1, 0, 1, 0, 9, 0, 64'd0); #1;
      check("starve_denied", bus.ic_ack_tag, 4'd0);
      cycle();
    end
    drive(1, 0, 1, 0, 9, 0, 64'd0); #1;
    check("starve_grant", bus.ic_ack_tag, 4'd9);
    check("starve_st_held", bus.st_ack, 1'b0);
    cycle();
    drive(1, 0, 1, 0, 9, 0, 64'd0); #1;
    check("starve_reset", bus.st_ack, 1'b1);
    cycle();

    // squash kills outstanding loads, not stores
    for (int t = 1; t <= 3; t++) begin drive(0, 1, 0, t - 1, t, 0, 64'd0); cycle(); end
    check("three_live", outstanding_loads, 5'd3);
    squash = 1'b1;
    drive(1, 0, 0, 0, 5, 0, 64'd0); #1;
    check("squash_st_ack", bus.st_ack, 1'b1);
    cycle();
    squash = 1'b0;
    check("squash_out", outstanding_loads, 5'd0);
    drive(0, 0, 0, 0, 0, 2, 64'h55); #1;
    check("squash_ret", bus.ld_ret_valid, 1'b0);
    cycle();

    // reject then accept
    drive(0, 1, 0, 3, 0, 0, 64'd0); #1;
    check("rej_ack", bus.ld_ack, 1'b0);
    check("rej_cmd", bus.proc2mem_command, 2'd1);
    cycle();
    check("rej_out", outstanding_loads, 5'd0);
    drive(0, 1, 0, 3, 6, 0, 64'd0); #1;
    check("acc_ack", bus.ld_ack, 1'b1);
    cycle();
    check("acc_out", outstanding_loads, 5'd1);

    // same-tag return and reallocation
    drive(0, 1, 0, 1, 5, 0, 64'd0); cycle();
    drive(0, 1, 0, 2, 5, 5, 64'hAA); #1;
    check("reuse_old_pos", bus.ld_ret_lq_pos, 3'd1);
    cycle();
    check("reuse_out", outstanding_loads, 5'd2);
    drive(0, 0, 0, 0, 0, 5, 64'hBB); #1;
    check("reuse_new_pos", bus.ld_ret_lq_pos, 3'd2);
    cycle();

    // reset forgets tags
    drive(0, 1, 0, 4, 7, 0, 64'd0); cycle();
    reset = 1'b1;
    drive(0, 1, 0, 4, 8, 0, 64'd0); #1;
    check("midrst_ld_ack", bus.ld_ack, 1'b0);
    cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 7, 64'h77); #1;
    check("midrst_ret", bus.ld_ret_valid, 1'b0);
    cycle();
    check("midrst_out", outstanding_loads, 5'd0);

    for (int n = 0; n < 500; n++) begin
      reset  = ($urandom_range(0, 63) == 0);
      squash = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15),
            $urandom_range(0, 15), {$urandom, $urandom});
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ls_mem_arbiter.md
Name: ls_mem_arbiter

Overview:
- Shares the single processor-to-memory port among three requesters: committed-store drain from the store queue, load issue from the load queue/fu_ls path, and instruction-cache miss fetch.
- Tracks outstanding load transactions by memory tag and routes returning data back to the owning load-queue slot.
- Drops load data belonging to squashed loads.
- Prevents icache starvation with an age counter.

Parameters:
- LSQ_IDX_LEN, 3, width of load-queue position index.
- TAG_W, 4, memory transaction tag width; tag 0 means no response.
- STARVE_LIMIT, 8, cycles an icache request may be denied before it is promoted to top priority.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- squash  in  1  pipeline flush; kills all outstanding loads
- st_req_valid  in  1  store queue head committed and ready to write
- st_req_addr  in  32  store byte address
- st_req_data  in  64  store data, already aligned
- st_req_size  in  2  MEM_SIZE (BYTE/HALF/WORD/DOUBLE)
- st_ack  out  1  store accepted by memory this cycle
- ld_req_valid  in  1  load ready to access memory
- ld_req_addr  in  32  load address
- ld_req_size  in  2  load MEM_SIZE
- ld_req_lq_pos  in  LSQ_IDX_LEN  owning load-queue slot
- ld_ack  out  1  load accepted by memory this cycle
- ld_ret_valid  out  1  load data returning this cycle
- ld_ret_data  out  64  returned data (mem2proc_data)
- ld_ret_lq_pos  out  LSQ_IDX_LEN  slot for the returned data
- ic_req_valid  in  1  icache miss request
- ic_req_addr  in  32  icache block address
- ic_ack_tag  out  TAG_W  mem2proc_response forwarded when icache granted, else 0
- proc2mem_command  out  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2
- proc2mem_addr  out  32  address to memory
- proc2mem_data  out  64  store data
- proc2mem_size  out  2  access size
- mem2proc_response  in  TAG_W  accept tag; 0 = rejected
- mem2proc_data  in  64  returning data
- mem2proc_tag  in  TAG_W  tag of returning data; 0 = none
- outstanding_loads  out  TAG_W+1  count of live load tags

Behaviour:
- Arbitration is combinational and same-cycle.
- Default priority: store > load > icache.
- If ic_starve_cnt >= STARVE_LIMIT, priority becomes icache > store > load.
- With no requester valid, the port drives command BUS_NONE and addr/data/size = 0.
- Icache grant drives size DOUBLE; loads and stores drive their own size.
- Grant accepted iff mem2proc_response != 0. Then:
  - st_ack or ld_ack pulses, or ic_ack_tag = mem2proc_response.
  - On reject, no ack; requesters hold their valid and payload.
- ic_starve_cnt (registered):
  - reset to 0 on reset;
  - cleared to 0 when icache is accepted or ic_req_valid is low;
  - incremented (saturating) when ic_req_valid is high and icache is not accepted.
- Tag table: 2^TAG_W entries {valid, lq_pos}, all cleared on reset. Entry 0 is never written.
  - On an accepted load with squash low: entry[mem2proc_response] gets valid=1, lq_pos=ld_req_lq_pos, written at the clock edge.
- Return path:
  - When mem2proc_tag != 0, entry[mem2proc_tag].valid=1, and squash is low: ld_ret_valid=1 combinationally, ld_ret_data=mem2proc_data, ld_ret_lq_pos=entry.lq_pos.
  - The entry is cleared at the same edge.
  - A matching icache tag finds no valid entry, so ld_ret_valid=0; the icache snoops the tag itself.
- Squash:
  - Clears every valid bit at the edge.
  - Forces ld_ret_valid=0 that cycle.
  - A load accepted in the squash cycle is not recorded.
  - st_ack and store issue are unaffected; committed stores are never killed.
  - ld_ack is still reported during squash.
- Simultaneous return and allocation of the same tag: clear first, then allocate. The entry ends valid with the new lq_pos.
- outstanding_loads equals the popcount of valid entries. It is registered and matches the table after each edge.
- Reset outputs: all acks 0, ld_ret_valid 0, ic_ack_tag 0, outstanding_loads 0, command BUS_NONE.
- Reset mid-transaction: all tags are forgotten; later returns are ignored.
- Latency:
  - request-to-ack is 0 cycles when granted and accepted;
  - data return is memory-dependent; routing adds 0 cycles.

Test Plan:
- Store and load valid together, response=3: command BUS_STORE, st_ack=1, ld_ack=0. Next cycle response=4: BUS_LOAD, ld_ack=1, entry4 lq_pos recorded, outstanding_loads=1.
- Load lq_pos=5 accepted with tag 7; later mem2proc_tag=7, data=0xDEADBEEF_00000001: ld_ret_valid=1, ld_ret_lq_pos=5, data matches, outstanding_loads back to 0.
- Store held valid continuously with icache valid, STARVE_LIMIT=8: icache is denied 8 cycles, then granted on the 9th; ic_ack_tag = response; counter resets to 0.
- Three loads outstanding (tags 1,2,3), squash pulse: outstanding_loads=0. Subsequent mem2proc_tag=2 gives ld_ret_valid=0. A store accepted in the squash cycle still gets st_ack=1.
- mem2proc_response=0 while load valid: ld_ack=0, command still BUS_LOAD, no table write. Next cycle response=6 gives ld_ack=1.
- Same cycle: return tag 5 (old lq_pos 1) and new load accepted with tag 5 (lq_pos 2): ld_ret_lq_pos=1 that cycle; afterwards entry5 holds lq_pos=2 and outstanding_loads is unchanged.
